// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte enables, valid/ready ports, 1-2 cycle read latency and a
// zeroing init sequencer. Define DUAL_PORT_RAM_BE_PARITY_EN for per-byte parity and rd_perr_o.
module dual_port_ram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 128,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RDW_MODE   = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    output logic                    busy_o,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic                    rd_valid_i,
    output logic                    rd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    output logic [DATA_WIDTH/8-1:0] rd_perr_o,
`endif
    output logic                    rd_valid_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LastW  = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CntOne = (ADDR_WIDTH + 1)'(1);
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    localparam int unsigned PayW = DATA_WIDTH + NumBytes;
`else
    localparam int unsigned PayW = DATA_WIDTH;
`endif

    typedef enum logic {StInit, StRun} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  busy_q;
    logic                  rdy_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  wr_fire, rd_fire, wr_in_range, rd_in_range, bypass;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [PayW-1:0]       rd_pay, pipe_pay, out_pay_q;
    logic                  pipe_valid, out_valid_q;

    assign wr_fire     = wr_valid_i && rdy_q;
    assign rd_fire     = rd_valid_i && rdy_q;
    assign wr_in_range = {1'b0, wr_addr_i} < DepthW;
    assign rd_in_range = {1'b0, rd_addr_i} < DepthW;
    assign bypass      = (RDW_MODE == 1) && wr_fire && (wr_addr_i == rd_addr_i);

    // Counter is one bit wider than the address so a non-power-of-2 depth still terminates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + CntOne;
                    if (cnt_q == LastW) begin
                        state_q <= StRun;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                StRun: begin
                    if (clr_i) begin
                        state_q <= StInit;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
        end else if (wr_fire && wr_in_range) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (wr_be_i[k]) mem_q[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[rd_addr_i];
            if (bypass) begin
                for (int k = 0; k < NumBytes; k++) begin
                    if (wr_be_i[k]) rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
                end
            end
        end
    end

`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    logic [NumBytes-1:0] par_q [MEM_DEPTH];
    logic [NumBytes-1:0] rd_perr;

    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            par_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
        end else if (wr_fire && wr_in_range) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (wr_be_i[k]) par_q[wr_addr_i][k] <= ^wr_data_i[8*k +: 8];
            end
        end
    end

    // Forwarded bytes never flag an error: their parity is fresh by construction.
    always_comb begin
        rd_perr = '0;
        if (rd_in_range) begin
            for (int k = 0; k < NumBytes; k++) begin
                rd_perr[k] = par_q[rd_addr_i][k] != (^mem_q[rd_addr_i][8*k +: 8]);
                if (bypass && wr_be_i[k]) rd_perr[k] = 1'b0;
            end
        end
    end

    assign rd_pay    = {rd_perr, rd_word};
    assign rd_perr_o = out_pay_q[PayW-1:DATA_WIDTH];
`else
    assign rd_pay = rd_word;
`endif

    if (RD_LATENCY == 2) begin : g_lat2
        logic            s1_valid_q;
        logic [PayW-1:0] s1_pay_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_valid_q <= 1'b0;
                s1_pay_q   <= '0;
            end else begin
                s1_valid_q <= rd_fire;
                if (rd_fire) s1_pay_q <= rd_pay;
            end
        end

        assign pipe_valid = s1_valid_q;
        assign pipe_pay   = s1_pay_q;
    end else begin : g_lat1
        assign pipe_valid = rd_fire;
        assign pipe_pay   = rd_pay;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_pay_q   <= '0;
        end else begin
            out_valid_q <= pipe_valid;
            if (pipe_valid) out_pay_q <= pipe_pay;
        end
    end

    assign busy_o     = busy_q;
    assign wr_ready_o = rdy_q;
    assign rd_ready_o = rdy_q;
    assign rd_valid_o = out_valid_q;
    assign rd_data_o  = out_pay_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances (latency 1 / old-data, latency 2 / new-data)
// share one stimulus stream and are checked against hand-computed vectors.
module tb_dual_port_ram_be;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        wr_valid = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_valid = 1'b0;
    logic [6:0]  rd_addr = '0;

    logic        a_busy, a_wrdy, a_rrdy, a_valid;
    logic [31:0] a_data;
    logic        b_busy, b_wrdy, b_rrdy, b_valid;
    logic [31:0] b_data;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    logic [3:0]  a_perr, b_perr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(.RD_LATENCY(1), .RDW_MODE(0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(a_busy),
        .wr_valid_i(wr_valid), .wr_ready_o(a_wrdy), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be),
        .rd_valid_i(rd_valid), .rd_ready_o(a_rrdy), .rd_addr_i(rd_addr),
        .rd_data_o(a_data),
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        .rd_perr_o(a_perr),
`endif
        .rd_valid_o(a_valid)
    );

    dual_port_ram_be #(.RD_LATENCY(2), .RDW_MODE(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(b_busy),
        .wr_valid_i(wr_valid), .wr_ready_o(b_wrdy), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be),
        .rd_valid_i(rd_valid), .rd_ready_o(b_rrdy), .rd_addr_i(rd_addr),
        .rd_data_o(b_data),
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        .rd_perr_o(b_perr),
`endif
        .rd_valid_o(b_valid)
    );

    typedef struct {
        logic        wr;
        logic [6:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic [6:0]  ra;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    localparam int NumVec = 15;
    vec_t vecs [NumVec];

    function automatic vec_t mk(input logic wr, input logic [6:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic rd, input logic [6:0] ra,
                                input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.be = be;
        v.rd = rd; v.ra = ra; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0; rd_valid = 1'b0; clr = 1'b0; wr_be = '0;
    endtask

    // Single read: instance a answers one cycle after accept, instance b two cycles after.
    task automatic do_read(input string name, input logic [6:0] addr,
                           input logic [31:0] ea, input logic [31:0] eb);
        rd_valid = 1'b1; rd_addr = addr;
        tick();
        rd_valid = 1'b0;
        check({name, " a_valid"}, 64'(a_valid), 64'd1);
        check({name, " a_data"}, 64'(a_data), 64'(ea));
        check({name, " b_early"}, 64'(b_valid), 64'd0);
        tick();
        check({name, " a_pulse"}, 64'(a_valid), 64'd0);
        check({name, " b_valid"}, 64'(b_valid), 64'd1);
        check({name, " b_data"}, 64'(b_data), 64'(eb));
    endtask

    // Counts cycles with busy high; optionally presses requests to prove they are ignored.
    task automatic wait_init(input string name, input int start, input logic poke);
        int n = start;
        int spurious = 0;
        if (poke) begin
            wr_valid = 1'b1; wr_addr = 7'd8; wr_data = 32'h5555_5555; wr_be = 4'hF;
            rd_valid = 1'b1; rd_addr = 7'd5;
        end
        while (a_busy && n < 300) begin
            tick();
            n++;
            if (a_busy && (a_valid || b_valid)) spurious++;
        end
        idle();
        check({name, " busy_cycles"}, 64'(n), 64'd128);
        check({name, " spurious_valid"}, 64'(spurious), 64'd0);
        check({name, " b_busy"}, 64'(b_busy), 64'd0);
        check({name, " readies"}, {60'd0, a_wrdy, a_rrdy, b_wrdy, b_rrdy}, 64'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(0, 0,   32'h0,         4'h0, 1, 0,   32'h0,         32'h0);
        vecs[1]  = mk(1, 5,   32'hAABBCCDD,  4'hF, 0, 0,   32'h0,         32'h0);
        vecs[2]  = mk(1, 5,   32'h11223344,  4'h5, 0, 0,   32'h0,         32'h0);
        vecs[3]  = mk(0, 0,   32'h0,         4'h0, 1, 5,   32'hAA22CC44,  32'hAA22CC44);
        vecs[4]  = mk(1, 9,   32'hFFFFFFFF,  4'hF, 0, 0,   32'h0,         32'h0);
        vecs[5]  = mk(1, 9,   32'h12345678,  4'hF, 1, 9,   32'hFFFFFFFF,  32'h12345678);
        vecs[6]  = mk(0, 0,   32'h0,         4'h0, 1, 9,   32'h12345678,  32'h12345678);
        vecs[7]  = mk(1, 9,   32'hA5A5A5A5,  4'h6, 1, 9,   32'h12345678,  32'h12A5A578);
        vecs[8]  = mk(0, 0,   32'h0,         4'h0, 1, 9,   32'h12A5A578,  32'h12A5A578);
        vecs[9]  = mk(1, 10,  32'hDEADBEEF,  4'h0, 1, 10,  32'h0,         32'h0);
        vecs[10] = mk(0, 0,   32'h0,         4'h0, 1, 127, 32'h0,         32'h0);
        vecs[11] = mk(1, 20,  32'hCAFEF00D,  4'hF, 1, 21,  32'h0,         32'h0);
        vecs[12] = mk(0, 0,   32'h0,         4'h0, 1, 20,  32'hCAFEF00D,  32'hCAFEF00D);
        vecs[13] = mk(1, 127, 32'h0BADF00D,  4'h8, 1, 127, 32'h0,         32'h0B000000);
        vecs[14] = mk(0, 0,   32'h0,         4'h0, 1, 127, 32'h0B000000,  32'h0B000000);

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst busy", {62'd0, a_busy, b_busy}, 64'h3);
        check("rst readies", {60'd0, a_wrdy, a_rrdy, b_wrdy, b_rrdy}, 64'h0);
        check("rst valid", {62'd0, a_valid, b_valid}, 64'h0);
        check("rst data", {a_data, b_data}, 64'h0);
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        check("rst perr", {56'd0, a_perr, b_perr}, 64'h0);
`endif
        rst_n = 1'b1;
        wait_init("init", 0, 1'b0);

        for (int i = 0; i < NumVec; i++) begin
            wr_valid = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            wr_be = vecs[i].be; rd_valid = vecs[i].rd; rd_addr = vecs[i].ra;
            tick();
            idle();
            check($sformatf("vec%0d a_valid", i), 64'(a_valid), 64'(vecs[i].rd));
            if (vecs[i].rd) check($sformatf("vec%0d a_data", i), 64'(a_data), 64'(vecs[i].exp_a));
            check($sformatf("vec%0d b_early", i), 64'(b_valid), 64'd0);
            tick();
            check($sformatf("vec%0d a_pulse", i), 64'(a_valid), 64'd0);
            check($sformatf("vec%0d b_valid", i), 64'(b_valid), 64'(vecs[i].rd));
            if (vecs[i].rd) check($sformatf("vec%0d b_data", i), 64'(b_data), 64'(vecs[i].exp_b));
        end

        // Clear with a read of addr 5 and a write of addr 7 accepted in the same cycle
        clr = 1'b1; rd_valid = 1'b1; rd_addr = 7'd5;
        wr_valid = 1'b1; wr_addr = 7'd7; wr_data = 32'h77; wr_be = 4'hF;
        tick();
        idle();
        check("clr a_valid", 64'(a_valid), 64'd1);
        check("clr a_data", 64'(a_data), 64'hAA22CC44);
        check("clr busy", {62'd0, a_busy, b_busy}, 64'h3);
        check("clr readies", {60'd0, a_wrdy, a_rrdy, b_wrdy, b_rrdy}, 64'h0);
        tick();
        check("clr b_valid", 64'(b_valid), 64'd1);
        check("clr b_data", 64'(b_data), 64'hAA22CC44);
        wait_init("clr", 1, 1'b1);
        do_read("post_clr addr5", 7'd5, 32'h0, 32'h0);
        do_read("post_clr addr7", 7'd7, 32'h0, 32'h0);
        do_read("init_write_ignored", 7'd8, 32'h0, 32'h0);

        // Streaming reads
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_addr = 7'(i); wr_data = 32'(i * 3); wr_be = 4'hF;
            tick();
        end
        idle();
        for (int c = 0; c < 18; c++) begin
            rd_valid = (c < 16); rd_addr = 7'(c);
            tick();
            check($sformatf("stream%0d a_valid", c), 64'(a_valid), 64'(c < 16));
            if (c < 16) check($sformatf("stream%0d a_data", c), 64'(a_data), 64'(c * 3));
            check($sformatf("stream%0d b_valid", c), 64'(b_valid), 64'(c >= 1 && c < 17));
            if (c >= 1 && c < 17)
                check($sformatf("stream%0d b_data", c), 64'(b_data), 64'((c - 1) * 3));
        end
        idle();

`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        wr_valid = 1'b1; wr_addr = 7'd3; wr_data = 32'h0000AB00; wr_be = 4'hF;
        tick();
        idle();
        u_dut_a.par_q[3][1] <= ~u_dut_a.par_q[3][1];
        #1;
        rd_valid = 1'b1; rd_addr = 7'd3;
        tick();
        rd_valid = 1'b0;
        check("par a_data", 64'(a_data), 64'h0000AB00);
        check("par a_perr", 64'(a_perr), 64'h2);
        tick();
        check("par b_perr", 64'(b_perr), 64'h0);
`endif

        // Reset with reads in flight in the latency-2 instance
        rd_valid = 1'b1; rd_addr = 7'd4;
        tick();
        rd_addr = 7'd5;
        tick();
        check("midrst b_valid_before", 64'(b_valid), 64'd1);
        check("midrst b_data_before", 64'(b_data), 64'd12);
        rst_n = 1'b0;
        idle();
        #1;
        check("midrst valid", {62'd0, a_valid, b_valid}, 64'h0);
        check("midrst data", {a_data, b_data}, 64'h0);
        check("midrst busy", {62'd0, a_busy, b_busy}, 64'h3);
        tick();
        tick();
        check("midrst flushed", {62'd0, a_valid, b_valid}, 64'h0);
        rst_n = 1'b1;
        wait_init("midrst", 0, 1'b0);
        do_read("post_rst addr5", 7'd5, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Parametrised simple dual-port RAM: one write port, one independent read port, single clock domain. Successor to the existing 8x128 dual-port memory.
- Adds per-byte write enables, valid/ready handshake per port, configurable read latency and read-during-write policy.
- Adds a self-clearing init sequencer that zeroes the array after reset or on request.
- Sits behind bus adapters as a generic scratchpad/buffer macro.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- MEM_DEPTH, 128, number of words; must be ≥ 2.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- RD_LATENCY, 1, read-accept to data cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data, 1 = read returns new (byte-merged) data.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  request full-array clear; sampled only in RUN.
- busy_o  out  1  high while the array is being cleared.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write port ready.
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_be_i  in  DATA_WIDTH/8  byte enables; bit k covers byte [8k+7:8k].
- rd_valid_i  in  1  read request.
- rd_ready_o  out  1  read port ready.
- rd_addr_i  in  ADDR_WIDTH  read address.
- rd_data_o  out  DATA_WIDTH  read data; holds its value until the next read returns.
- rd_valid_o  out  1  one-cycle pulse marking rd_data_o as new.

Behaviour:
- **Reset (rst_ni low, async):**
  - state = INIT, clear counter = 0, busy_o = 1.
  - wr_ready_o = 0, rd_ready_o = 0, rd_valid_o = 0, rd_data_o = 0.
  - Read pipeline flushed.
  - Array is not reset directly; it is zeroed by INIT.
- **INIT state:**
  - One word per cycle, address = counter, all bytes written to 0. Counter increments.
  - After address MEM_DEPTH-1 is written, go to RUN.
  - busy_o falls and both readies rise in the cycle after the last clear write, so INIT lasts exactly MEM_DEPTH cycles.
  - All requests are ignored while in INIT.
- **RUN state:**
  - wr_ready_o = rd_ready_o = 1.
  - Write fires when wr_valid_i && wr_ready_o: each byte k with wr_be_i[k]=1 is updated; other bytes are unchanged. wr_be_i = 0 is a legal no-op.
  - Read fires when rd_valid_i && rd_ready_o: rd_data_o is updated and rd_valid_o pulses RD_LATENCY cycles after the accept edge. Back-to-back reads give one result per cycle, in order.
  - Simultaneous read and write to different addresses are fully independent.
  - Same address in the same cycle follows RDW_MODE:
    - 0: pre-write word.
    - 1: write-enabled bytes from wr_data_i, other bytes from the array.
- **clr_i in RUN:**
  - Next state is INIT with counter = 0; readies drop the following cycle.
  - A write accepted in the same cycle as clr_i is performed, then overwritten by the clear.
  - Reads already in the pipeline complete with their pre-clear data.
- **Reset mid-operation:** pipeline contents are discarded, no rd_valid_o is produced, and INIT restarts after rst_ni rises.
- **Address wrap:** clear counter width is ADDR_WIDTH+1 so a non-power-of-2 MEM_DEPTH terminates correctly. Addresses ≥ MEM_DEPTH: writes ignored, reads return 0.

Optional Feature:
- Macro: DUAL_PORT_RAM_BE_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte, computed on write (INIT stores parity of 0).
  - Added output rd_perr_o (DATA_WIDTH/8 bits), aligned with rd_valid_o; bit k = stored parity != recomputed parity of byte k. Reset value 0.
  - In the RDW_MODE=1 bypass path, forwarded bytes carry freshly computed parity (no error).
- When undefined: no parity storage and no rd_perr_o port.

Test Plan:
- Reset then release → busy_o high for exactly 128 cycles, then readies = 1; read of addr 0 and addr 127 returns 0x00000000.
- Write addr 5 = 0xAABBCCDD with be=4'b1111, then addr 5 = 0x11223344 with be=4'b0101 → read addr 5 = 0xAA22CC44, rd_valid_o exactly RD_LATENCY cycles after accept (run with RD_LATENCY=1 and 2).
- Same cycle write addr 9 = 0x12345678 (be=1111, addr 9 previously 0xFFFFFFFF) and read addr 9 → 0xFFFFFFFF with RDW_MODE=0, 0x12345678 with RDW_MODE=1.
- Streaming reads addrs 0..15 on consecutive cycles after writing addr i = i*3 → 16 consecutive rd_valid_o pulses carrying 0,3,...,45, in order.
- Assert clr_i with a read of addr 5 in flight → read returns 0xAA22CC44, busy_o high 128 cycles, then addr 5 reads 0.
- Drop rst_ni mid-stream with 2 reads in flight (RD_LATENCY=2) → rd_valid_o = 0 immediately and stays 0 until new reads after INIT. With the parity macro defined, force a parity-bit flip on addr 3 byte 1 → rd_perr_o = 4'b0010.
